// File: rtl/obuf_pkg.sv
// Shared types and sizing for the output-buffer controller.
//   VEC_WIDTH : RAM word width (16 x INT4)
//   ARR_DEPTH : RAM depth, power of two
//   ADDR_W    : address width derived from ARR_DEPTH
package obuf_pkg;

  localparam int unsigned VEC_WIDTH = 64;
  localparam int unsigned ARR_DEPTH = 64;
  localparam int unsigned ADDR_W    = $clog2(ARR_DEPTH);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ARR_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } obuf_state_e;

  // One skid-buffer entry: read word plus the address it came from.
  typedef struct packed {
    logic [VEC_WIDTH-1:0] data;
    logic [ADDR_W-1:0]    addr;
  } skid_entry_t;

endpackage

// File: rtl/obuf_if.sv
// Bundle of PPU write, drain control, RAM port, readout stream and status.
//   slave  : controller view (i_* inputs, o_* outputs)
//   master : environment view (PPU, RAM, readout sink)
interface obuf_if;
  import obuf_pkg::*;

  logic                 i_wr_en;
  logic [ADDR_W-1:0]    i_wr_addr;
  logic [VEC_WIDTH-1:0] i_wr_data;
  logic                 i_mtrx_done;

  logic                 o_ram_we;
  logic [ADDR_W-1:0]    o_ram_addr;
  logic [VEC_WIDTH-1:0] o_ram_data;
  logic [VEC_WIDTH-1:0] i_ram_q;

  logic                 o_rd_valid;
  logic                 i_rd_ready;
  logic [VEC_WIDTH-1:0] o_rd_data;
  logic [ADDR_W-1:0]    o_rd_addr;
  logic                 o_rd_last;

  logic                 o_busy;
  logic                 o_drain_done;
  logic                 o_err;

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_mtrx_done, i_ram_q, i_rd_ready,
    output o_ram_we, o_ram_addr, o_ram_data, o_rd_valid, o_rd_data,
           o_rd_addr, o_rd_last, o_busy, o_drain_done, o_err
  );

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_mtrx_done, i_ram_q, i_rd_ready,
    input  o_ram_we, o_ram_addr, o_ram_data, o_rd_valid, o_rd_data,
           o_rd_addr, o_rd_last, o_busy, o_drain_done, o_err
  );

endinterface

// File: rtl/obuf_skid.sv
// Two-entry FIFO absorbing the RAM read latency on the readout stream.
//   push/push_entry : write one entry (ignored when full and not popping)
//   pop             : remove head (ignored when empty)
//   occ             : occupancy 0..2
//   head            : oldest entry, held stable until popped
module obuf_skid
  import obuf_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        push,
  input  skid_entry_t push_entry,
  input  logic        pop,
  output logic [1:0]  occ,
  output skid_entry_t head
);

  skid_entry_t slot0;
  skid_entry_t slot1;
  logic [1:0]  occ_q;
  logic        do_pop;
  logic        do_push;

  assign do_pop  = pop && (occ_q != 2'd0);
  assign do_push = push && ((occ_q != 2'd2) || do_pop);
  assign occ     = occ_q;
  assign head    = slot0;

  // slot0 is always the head; slot1 shifts down on pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) slot0 <= push_entry;
          else               slot1 <= push_entry;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            slot0 <= push_entry;
          end else begin
            slot0 <= slot1;
            slot1 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/obuf_ctrl.sv
// Output-buffer controller: arbitrates the single-port output RAM between
// PPU writes (always win) and an in-order drain to a valid/ready stream.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : PPU write, i_mtrx_done, RAM port, readout, status
module obuf_ctrl
  import obuf_pkg::*;
(
  input logic   i_clk,
  input logic   i_rst_n,
  obuf_if.slave bus
);

  obuf_state_e       state;
  obuf_state_e       state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [ADDR_W-1:0] inflight_addr;
  logic              inflight;
  logic              err;
  logic              err_nxt;
  logic              busy;
  logic              drain_done;

  logic [1:0]        occ;
  skid_entry_t       head;
  skid_entry_t       push_entry;

  logic              rd_valid;
  logic              pop_c;
  logic              issue_c;
  logic              late_wr_c;
  logic [2:0]        credit_c;

  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [VEC_WIDTH-1:0] ram_data_c;

  assign rd_valid = (occ != 2'd0);
  assign pop_c    = rd_valid & bus.i_rd_ready;

  // Entries the skid buffer will hold once the in-flight read lands;
  // pop never exceeds occ so this cannot underflow.
  assign credit_c = 3'(occ) + 3'(inflight) - 3'(pop_c);
  assign issue_c  = (state == ST_DRAIN) && !bus.i_wr_en && (credit_c < 3'd2);

  assign late_wr_c = bus.i_wr_en && ((state == ST_DRAIN) || (state == ST_FLUSH))
                     && (bus.i_wr_addr < rd_ptr);

  // Next-state, read pointer and sticky error.
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    err_nxt    = err;
    case (state)
      ST_IDLE: begin
        if (bus.i_mtrx_done) begin
          state_nxt  = ST_DRAIN;
          rd_ptr_nxt = '0;
          err_nxt    = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (issue_c && (rd_ptr == LAST_ADDR)) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Empty after this cycle's pop and nothing left to land.
        if (!inflight && (occ == 2'(pop_c))) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (issue_c && (rd_ptr != LAST_ADDR)) rd_ptr_nxt = rd_ptr + ADDR_W'(1);
    if (bus.i_mtrx_done && (state != ST_IDLE)) err_nxt = 1'b1;
    if (late_wr_c) err_nxt = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      drain_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_ptr     <= rd_ptr_nxt;
      inflight   <= issue_c;
      err        <= err_nxt;
      busy       <= (state_nxt != ST_IDLE);
      drain_done <= (state_nxt == ST_DONE);
      if (issue_c) inflight_addr <= rd_ptr;
    end
  end

  // RAM port mux: a PPU write owns the port in any state.
  always_comb begin
    ram_we_c   = 1'b0;
    ram_addr_c = '0;
    ram_data_c = '0;
    if (bus.i_wr_en) begin
      ram_we_c   = 1'b1;
      ram_addr_c = bus.i_wr_addr;
      ram_data_c = bus.i_wr_data;
    end else if (state == ST_DRAIN) begin
      ram_addr_c = rd_ptr;
    end
  end

  assign push_entry = '{data: bus.i_ram_q, addr: inflight_addr};

  obuf_skid u_skid (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop_c),
    .occ        (occ),
    .head       (head)
  );

  assign bus.o_ram_we     = ram_we_c;
  assign bus.o_ram_addr   = ram_addr_c;
  assign bus.o_ram_data   = ram_data_c;
  assign bus.o_rd_valid   = rd_valid;
  assign bus.o_rd_data    = head.data;
  assign bus.o_rd_addr    = head.addr;
  assign bus.o_rd_last    = rd_valid && (head.addr == LAST_ADDR);
  assign bus.o_busy       = busy;
  assign bus.o_drain_done = drain_done;
  assign bus.o_err        = err;

endmodule

// File: tb/tb_obuf_ctrl.sv
// Directed bench for obuf_ctrl with a 1-cycle-latency RAM model.
module tb_obuf_ctrl;
  import obuf_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0]    addr;
    logic [VEC_WIDTH-1:0] data;
    logic                 last;
    int                   rel;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  obuf_if bus ();

  obuf_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [VEC_WIDTH-1:0] mem [ARR_DEPTH];

  always @(posedge clk) begin
    if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_data;
    bus.i_ram_q <= mem[bus.o_ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [VEC_WIDTH-1:0] exp_mem [ARR_DEPTH];
  logic [VEC_WIDTH-1:0] snap    [ARR_DEPTH];
  beat_t beats [$];
  int    done_cyc, done_cnt, first_busy, last_busy, stall_viol, occ_viol;
  logic  err_at2, err_last;
  bit    ended;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VEC_WIDTH-1:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {8{b}};
  endfunction

  task automatic check_zero(input string pfx);
    check({pfx, "_ram_we"},     64'(bus.o_ram_we),     64'd0);
    check({pfx, "_ram_addr"},   64'(bus.o_ram_addr),   64'd0);
    check({pfx, "_ram_data"},   64'(bus.o_ram_data),   64'd0);
    check({pfx, "_rd_valid"},   64'(bus.o_rd_valid),   64'd0);
    check({pfx, "_rd_data"},    64'(bus.o_rd_data),    64'd0);
    check({pfx, "_rd_addr"},    64'(bus.o_rd_addr),    64'd0);
    check({pfx, "_rd_last"},    64'(bus.o_rd_last),    64'd0);
    check({pfx, "_busy"},       64'(bus.o_busy),       64'd0);
    check({pfx, "_drain_done"}, 64'(bus.o_drain_done), 64'd0);
    check({pfx, "_err"},        64'(bus.o_err),        64'd0);
  endtask

  // Pulse i_mtrx_done at relative cycle 0 and run until done+2 or reset+3.
  task automatic run_drain(input int wr_cyc, input logic [ADDR_W-1:0] waddr,
                           input logic [VEC_WIDTH-1:0] wdata, input int dup_cyc,
                           input int rst_cyc, input bit bp);
    logic [VEC_WIDTH-1:0] pd;
    logic [ADDR_W-1:0]    pa;
    logic                 pl;
    bit                   pstall;
    beat_t                b;
    beats.delete();
    done_cyc = -1; done_cnt = 0; first_busy = -1; last_busy = -1;
    stall_viol = 0; occ_viol = 0; err_at2 = 1'b0; err_last = 1'b0; ended = 1'b0;
    pstall = 1'b0; pd = '0; pa = '0; pl = 1'b0;
    foreach (exp_mem[i]) snap[i] = exp_mem[i];
    @(posedge clk); #1;
    for (int r = 0; r < 400; r++) begin
      bus.i_mtrx_done = (r == 0) || (r == dup_cyc);
      bus.i_wr_en     = (r == wr_cyc);
      bus.i_wr_addr   = waddr;
      bus.i_wr_data   = wdata;
      if (r == wr_cyc) exp_mem[waddr] = wdata;
      rst_n           = (r != rst_cyc);
      bus.i_rd_ready  = bp ? ((r % 4 == 0) || (r % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (r == wr_cyc) begin
        check("wr_we",   64'(bus.o_ram_we),   64'd1);
        check("wr_addr", 64'(bus.o_ram_addr), 64'(waddr));
        check("wr_data", bus.o_ram_data,      wdata);
      end
      if (r == rst_cyc) check_zero("mid_rst");
      if (rst_n && bus.o_rd_valid && bus.i_rd_ready) begin
        b.addr = bus.o_rd_addr; b.data = bus.o_rd_data; b.last = bus.o_rd_last; b.rel = r;
        beats.push_back(b);
      end
      if (bus.o_drain_done) begin done_cnt++; done_cyc = r; end
      if (bus.o_busy) begin
        if (first_busy < 0) first_busy = r;
        last_busy = r;
      end
      if (pstall && (!bus.o_rd_valid || bus.o_rd_data != pd || bus.o_rd_addr != pa
                     || bus.o_rd_last != pl)) stall_viol++;
      pstall = bus.o_rd_valid && !bus.i_rd_ready;
      pd = bus.o_rd_data; pa = bus.o_rd_addr; pl = bus.o_rd_last;
      if (dut.u_skid.occ > 2'd2) occ_viol++;
      if (r == 2) err_at2 = bus.o_err;
      err_last = bus.o_err;
      if ((done_cyc >= 0 && r >= done_cyc + 2) || (rst_cyc >= 0 && r >= rst_cyc + 3)) begin
        ended = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.i_mtrx_done = 1'b0;
    bus.i_wr_en     = 1'b0;
    bus.i_rd_ready  = 1'b1;
    rst_n           = 1'b1;
    check("drain_end", 64'(ended), 64'd1);
  endtask

  // Beats must be addresses 0.. in order with snapshot data; when timed,
  // beat i lands on cycle 3+i, one later from index bump onward.
  task automatic verify_beats(input int n_exp, input bit timed, input int bump);
    int exp_rel;
    check("beat_cnt", 64'(beats.size()), 64'(n_exp));
    for (int i = 0; i < beats.size() && i < n_exp; i++) begin
      check($sformatf("beat%0d_addr", i), 64'(beats[i].addr), 64'(i));
      check($sformatf("beat%0d_data", i), beats[i].data,      snap[i]);
      check($sformatf("beat%0d_last", i), 64'(beats[i].last), 64'(i == ARR_DEPTH - 1));
      if (timed) begin
        exp_rel = 3 + i + (((bump >= 0) && (i >= bump)) ? 1 : 0);
        check($sformatf("beat%0d_cyc", i), 64'(beats[i].rel), 64'(exp_rel));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.i_wr_en     = 1'b0;
    bus.i_wr_addr   = '0;
    bus.i_wr_data   = '0;
    bus.i_mtrx_done = 1'b0;
    bus.i_rd_ready  = 1'b1;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload RAM[a] = a replicated through the PPU port while idle.
    for (int a = 0; a < int'(ARR_DEPTH); a++) begin
      @(posedge clk); #1;
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = ADDR_W'(a);
      bus.i_wr_data = pat(a);
      exp_mem[a]    = pat(a);
    end
    @(posedge clk); #1;
    bus.i_wr_en = 1'b0;

    // Basic drain, ready held high.
    run_drain(-1, '0, '0, -1, -1, 1'b0);
    verify_beats(64, 1'b1, -1);
    check("basic_done_cyc",   64'(done_cyc),   64'd67);
    check("basic_done_cnt",   64'(done_cnt),   64'd1);
    check("basic_busy_first", 64'(first_busy), 64'd1);
    check("basic_busy_last",  64'(last_busy),  64'd67);
    check("basic_err",        64'(err_last),   64'd0);

    // Backpressure: ready 1,0,0,1 repeating.
    run_drain(-1, '0, '0, -1, -1, 1'b1);
    verify_beats(64, 1'b0, -1);
    check("bp_stall_stable", 64'(stall_viol), 64'd0);
    check("bp_occ_max",      64'(occ_viol),   64'd0);
    check("bp_done_cnt",     64'(done_cnt),   64'd1);

    // Write collision at cycle 10 on an address not yet drained.
    run_drain(10, 6'd40, 64'hC0FF_EE00_0000_0040, -1, -1, 1'b0);
    snap[40] = 64'hC0FF_EE00_0000_0040;
    verify_beats(64, 1'b1, 9);
    check("coll_done_cyc", 64'(done_cyc), 64'd68);
    check("coll_err",      64'(err_last), 64'd0);

    // Late write to an already drained address.
    run_drain(20, 6'd5, 64'hDEAD_0000_0000_0005, -1, -1, 1'b0);
    verify_beats(64, 1'b0, -1);
    check("late_err", 64'(err_last), 64'd1);

    // Overlapping start; also shows the late write reached RAM[5].
    run_drain(-1, '0, '0, 30, -1, 1'b0);
    verify_beats(64, 1'b1, -1);
    check("ovl_err_cleared", 64'(err_at2),  64'd0);
    check("ovl_err",         64'(err_last), 64'd1);
    check("ovl_done_cyc",    64'(done_cyc), 64'd67);
    check("ovl_done_cnt",    64'(done_cnt), 64'd1);

    // Reset on the cycle beat 20 would appear.
    run_drain(-1, '0, '0, -1, 23, 1'b0);
    verify_beats(20, 1'b1, -1);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);

    // Fresh drain after reset starts from address 0.
    run_drain(-1, '0, '0, -1, -1, 1'b0);
    verify_beats(64, 1'b1, -1);
    check("post_rst_done_cyc", 64'(done_cyc), 64'd67);
    check("post_rst_err",      64'(err_last), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obuf_ctrl.md
# obuf_ctrl

Output-buffer controller that owns the single-port 64×64-bit output RAM between the PPU and the host readout path. PPU writes always win the port and are never stalled. On matrix completion the block drains all 64 entries in address order through a valid/ready stream, using a credit-checked 2-entry skid buffer so the RAM's 1-cycle read latency never drops a beat.

## Interface
- VEC_WIDTH, 64, RAM word width (INT4 × 16)
- ARR_DEPTH, 64, RAM depth; power of two
- ADDR_W, 6, log2(ARR_DEPTH)

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_en  in  1  PPU write strobe
- i_wr_addr  in  ADDR_W  PPU write address
- i_wr_data  in  VEC_WIDTH  PPU write data
- i_mtrx_done  in  1  single-cycle pulse; starts a drain
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_W  RAM address, shared by read and write
- o_ram_data  out  VEC_WIDTH  RAM write data
- i_ram_q  in  VEC_WIDTH  RAM read data, valid 1 cycle after a read address
- o_rd_valid  out  1  readout beat valid
- i_rd_ready  in  1  readout sink ready
- o_rd_data  out  VEC_WIDTH  readout word
- o_rd_addr  out  ADDR_W  address of the current beat
- o_rd_last  out  1  beat is address ARR_DEPTH-1
- o_busy  out  1  state ≠ IDLE
- o_drain_done  out  1  single-cycle pulse when the drain completes
- o_err  out  1  sticky error: late write or overlapping start

Reset value of every output is 0.

## Operation
- FSM states: IDLE, DRAIN, FLUSH, DONE.
  - IDLE → DRAIN on i_mtrx_done. The transition clears rd_ptr and o_err.
  - DRAIN → FLUSH once read ARR_DEPTH-1 has been issued.
  - FLUSH → DONE when the skid buffer is empty and no read is in flight.
  - DONE → IDLE unconditionally. o_drain_done is 1 only in DONE.
- Port mux:
  - If i_wr_en=1, the port carries the write in that cycle: o_ram_we=1, addr/data are the write. This holds in every state.
  - Otherwise, in DRAIN, o_ram_addr=rd_ptr and a read is issued if credit allows.
- Credit rule: issue a read when (occ + inflight − pop) < 2.
  - occ is skid buffer occupancy (0..2).
  - inflight is a 1-bit flag for a read issued last cycle.
  - pop is o_rd_valid & i_rd_ready.
  - This gives 1 beat/cycle with ready held and guarantees the skid buffer never overflows.
- The cycle after an issued read, i_ram_q and its address are pushed into the skid buffer.
- Late write: i_wr_en in DRAIN/FLUSH with i_wr_addr < rd_ptr sets o_err. The write still lands in RAM; the stale value has already been drained.
- i_mtrx_done outside IDLE is ignored and sets o_err.
- rd_ptr increments only on an issued read and saturates at ARR_DEPTH-1 (no wrap).
- Reset mid-drain returns the block to IDLE with the skid buffer empty. RAM contents are untouched.

## Timing
- i_mtrx_done at cycle 0, i_rd_ready held high, no writes:
  - state=DRAIN at cycle 1, first read issued at cycle 1.
  - q at cycle 2; first o_rd_valid (addr 0) at cycle 3.
  - Last beat (o_rd_last, addr 63) at cycle 66.
  - o_drain_done at cycle 67, IDLE at cycle 68.
  - o_busy is high on cycles 1–67.
- Each PPU write in DRAIN delays the remaining beats by 1 cycle.
- o_rd_valid, once asserted, holds with stable data/addr/last until accepted.
- Readout outputs are driven from skid-buffer registers, with no combinational path from i_rd_ready. The only combinational path from i_rd_ready goes into the issue decision.

## Structure
- Shared package obuf_pkg holds:
  - the state enum (IDLE/DRAIN/FLUSH/DONE);
  - the ADDR_W derivation;
  - the skid entry struct {data, addr}.
- Sub-module obuf_skid: 2-entry FIFO with push, pop, occ, head outputs, async active-low reset.
- The FSM, port mux and credit logic stay in obuf_ctrl.

## Test plan
- Basic drain: preload RAM[a]=a replicated. Pulse i_mtrx_done with ready=1 → 64 beats, addr 0..63 on cycles 3..66, o_rd_last only on addr 63, o_drain_done at 67.
- Backpressure: ready toggles 1,0,0,1 repeating → every address delivered exactly once, in order. Data is stable while valid & !ready, and occ never exceeds 2.
- Write collision: PPU writes addr 40 at cycle 10 of the drain → o_ram_we=1 that cycle and no read issued. Drain ends at cycle 68, o_err=0.
- Late write: PPU writes addr 5 after addr 5 has been read → o_err=1 and RAM[5] updated. The next i_mtrx_done clears o_err.
- Overlapping start: second i_mtrx_done during DRAIN → ignored, o_err=1, exactly 64 beats delivered.
- Reset mid-drain: assert i_rst_n=0 at beat 20 → all outputs 0. A fresh i_mtrx_done after release drains from addr 0.
